// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: memory handshakes, branch flags and datapath controls.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_unit_if;
  logic [31:0] INST_CTRL;
  logic        INST_vld_CTRL;
  logic        BrEq_CTRL;
  logic        BrLt_CTRL;
  logic        D_MEM_rdy_CTRL;
  logic [3:0]  ALUsel_CTRL;
  logic [1:0]  WBACK_sel_CTRL;
  logic [2:0]  IMMsel_CTRL;
  logic        PCsel_CTRL;
  logic        PC_we_CTRL;
  logic        IR_we_CTRL;
  logic        REGFILE_en_CTRL;
  logic        Asel_CTRL;
  logic        Bsel_CTRL;
  logic        BrUn_CTRL;
  logic        D_MEM_re_CTRL;
  logic        D_MEM_we_CTRL;
  logic        TRAP_CTRL;

  modport master (
    input  INST_CTRL, INST_vld_CTRL, BrEq_CTRL,
    input  BrLt_CTRL, D_MEM_rdy_CTRL,
    output ALUsel_CTRL, WBACK_sel_CTRL, IMMsel_CTRL,
    output PCsel_CTRL, PC_we_CTRL, IR_we_CTRL,
    output REGFILE_en_CTRL, Asel_CTRL, Bsel_CTRL,
    output BrUn_CTRL, D_MEM_re_CTRL, D_MEM_we_CTRL,
    output TRAP_CTRL
  );

  modport slave (
    output INST_CTRL, INST_vld_CTRL, BrEq_CTRL,
    output BrLt_CTRL, D_MEM_rdy_CTRL,
    input  ALUsel_CTRL, WBACK_sel_CTRL, IMMsel_CTRL,
    input  PCsel_CTRL, PC_we_CTRL, IR_we_CTRL,
    input  REGFILE_en_CTRL, Asel_CTRL, Bsel_CTRL,
    input  BrUn_CTRL, D_MEM_re_CTRL, D_MEM_we_CTRL,
    input  TRAP_CTRL
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WBACK with a
// sticky TRAP for illegal opcodes and data-memory timeouts.
module multicycle_control_unit #(
  parameter int EN_BLT      = 1,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic CLK,
  input logic RST_N,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WBACK, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t               r_state, w_next;
  logic [31:0]          r_ir;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_rd_nz;
  logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
  logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
  logic       w_br_ok, w_legal, w_taken, w_mux_act;
  logic       w_unused;

  assign w_op     = r_ir[6:0];
  assign w_f3     = r_ir[14:12];
  assign w_f7b5   = r_ir[30];
  assign w_rd_nz  = (r_ir[11:7] != 5'd0);
  assign w_unused = &{1'b0, r_ir[31], r_ir[29:15]};

  assign w_is_r     = (w_op == OP_R);
  assign w_is_i     = (w_op == OP_I);
  assign w_is_ld    = (w_op == OP_LD);
  assign w_is_st    = (w_op == OP_ST);
  assign w_is_br    = (w_op == OP_BR);
  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_auipc = (w_op == OP_AUIPC);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_jalr  = (w_op == OP_JALR);

  // 010/011 never legal; the ordering compares only when enabled
  assign w_br_ok = (w_f3[2:1] != 2'b01) &&
                   (!w_f3[2] || (EN_BLT != 0));

  assign w_legal = w_is_r | w_is_i | w_is_ld | w_is_st |
                   w_is_lui | w_is_auipc | w_is_jal |
                   w_is_jalr | (w_is_br & w_br_ok);

  // Branch outcome from the comparator flags
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:        w_taken = bus.BrEq_CTRL;
      3'b001:        w_taken = !bus.BrEq_CTRL;
      3'b100, 3'b110: w_taken = bus.BrLt_CTRL;
      3'b101, 3'b111: w_taken = !bus.BrLt_CTRL;
      default:       w_taken = 1'b0;
    endcase
  end

  // State, instruction register and memory-wait counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_FETCH;
      r_ir    <= 32'h0000_0013;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (bus.IR_we_CTRL) r_ir <= bus.INST_CTRL;
    end
  end

  // EXEC mux settings, held through MEM and WBACK so the ALU result stays valid
  assign w_mux_act = (r_state == S_EXEC) || (r_state == S_MEM) ||
                     (r_state == S_WBACK);

  always_comb begin
    bus.ALUsel_CTRL = 4'b0000;
    bus.IMMsel_CTRL = 3'b000;
    bus.Asel_CTRL   = 1'b0;
    bus.Bsel_CTRL   = 1'b0;
    bus.BrUn_CTRL   = 1'b0;
    if (w_mux_act) begin
      unique case (1'b1)
        w_is_r: bus.ALUsel_CTRL = {w_f7b5, w_f3};
        w_is_i: begin
          bus.Bsel_CTRL   = 1'b1;
          bus.ALUsel_CTRL = {(w_f3 == 3'b101) & w_f7b5, w_f3};
        end
        w_is_ld, w_is_jalr: bus.Bsel_CTRL = 1'b1;
        w_is_st: begin
          bus.Bsel_CTRL   = 1'b1;
          bus.IMMsel_CTRL = 3'b001;
        end
        w_is_br: begin
          bus.Asel_CTRL   = 1'b1;
          bus.Bsel_CTRL   = 1'b1;
          bus.IMMsel_CTRL = 3'b010;
          bus.BrUn_CTRL   = w_f3[1];
        end
        w_is_auipc: begin
          bus.Asel_CTRL   = 1'b1;
          bus.Bsel_CTRL   = 1'b1;
          bus.IMMsel_CTRL = 3'b011;
        end
        w_is_jal: begin
          bus.Asel_CTRL   = 1'b1;
          bus.Bsel_CTRL   = 1'b1;
          bus.IMMsel_CTRL = 3'b100;
        end
        w_is_lui: begin
          bus.Bsel_CTRL   = 1'b1;
          bus.ALUsel_CTRL = 4'b1111;
          bus.IMMsel_CTRL = 3'b011;
        end
        default: ;
      endcase
    end
  end

  // Next state, enables and handshake requests
  always_comb begin
    w_next              = r_state;
    w_cnt_nxt           = '0;
    bus.WBACK_sel_CTRL  = 2'b01;
    bus.PCsel_CTRL      = 1'b0;
    bus.PC_we_CTRL      = 1'b0;
    bus.IR_we_CTRL      = 1'b0;
    bus.REGFILE_en_CTRL = 1'b0;
    bus.D_MEM_re_CTRL   = 1'b0;
    bus.D_MEM_we_CTRL   = 1'b0;
    bus.TRAP_CTRL       = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.IR_we_CTRL = bus.INST_vld_CTRL;
        if (bus.INST_vld_CTRL) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_br) begin
          bus.PC_we_CTRL = 1'b1;
          bus.PCsel_CTRL = w_taken;
          w_next         = S_FETCH;
        end else if (w_is_ld || w_is_st) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WBACK;
        end
      end
      S_MEM: begin
        bus.D_MEM_re_CTRL = w_is_ld;
        bus.D_MEM_we_CTRL = w_is_st;
        if (bus.D_MEM_rdy_CTRL) begin
          if (w_is_ld) begin
            w_next = S_WBACK;
          end else begin
            bus.PC_we_CTRL = 1'b1;
            w_next         = S_FETCH;
          end
        end else if (r_cnt == TIMEOUT_W'(MEM_TIMEOUT)) begin
          w_next = S_TRAP;
        end else begin
          w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
        end
      end
      S_WBACK: begin
        bus.REGFILE_en_CTRL = w_rd_nz;
        bus.PC_we_CTRL      = 1'b1;
        bus.PCsel_CTRL      = w_is_jal | w_is_jalr;
        if (w_is_ld)
          bus.WBACK_sel_CTRL = 2'b00;
        else if (w_is_jal || w_is_jalr)
          bus.WBACK_sel_CTRL = 2'b10;
        w_next = S_FETCH;
      end
      S_TRAP: bus.TRAP_CTRL = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

endmodule
